aes_decrypt: RTL and testbench



---
 rtl/aes_decrypt.sv | 229 ++++++++++++++++++++++
 tb/tb_aes_decrypt.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_decrypt.sv
// aes_decrypt: iterative AES-128 decryption engine, one round per clock.
// Round keys are never stored as an array: the cipher key is expanded forward
// to rk10 over ten cycles, then each decryption round walks the schedule
// backwards by one step to obtain the key it needs.
module aes_decrypt (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] block,
   input  logic [127:0] key,
   output logic [127:0] result,
   output logic         busy,
   output logic         done
);

   typedef enum logic [1:0] {IDLE, EXPAND, ROUND} fsm_e;

   fsm_e         fsm_q;
   logic [3:0]   cnt_q;
   logic [127:0] rk_q;
   logic [127:0] st_q;
   logic [127:0] result_q;
   logic         busy_q;
   logic         done_q;

   logic [127:0] rk_fwd_d;
   logic [127:0] rk_inv_d;
   logic [127:0] last_d;
   logic [127:0] round_d;

   // ---------------------------------------------------------------------
   // GF(2^8) arithmetic, polynomial 0x11b
   // ---------------------------------------------------------------------
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254; zero maps to zero naturally.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] p;
      logic [7:0] r;
      p = a;
      r = 8'h01;
      for (int i = 0; i < 7; i++) begin
         p = gf_mul(p, p);
         r = gf_mul(r, p);
      end
      return r;
   endfunction

   // Forward S-box: inverse followed by the affine transform.
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] v;
      v = gf_inv(a);
      return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
               ^ {v[3:0], v[7:4]} ^ 8'h63;
   endfunction

   // Inverse S-box: inverse affine transform followed by the inverse.
   function automatic logic [7:0] inv_sbox(input logic [7:0] a);
      logic [7:0] v;
      v = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
      return gf_inv(v);
   endfunction

   // ---------------------------------------------------------------------
   // Key schedule
   // ---------------------------------------------------------------------
   function automatic logic [7:0] rcon(input logic [3:0] i);
      case (i)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
      return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
   endfunction

   function automatic logic [127:0] key_step_fwd(input logic [127:0] rk, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3;
      w0 = rk[127:96] ^ sub_rot_word(rk[31:0]) ^ {rc, 24'h000000};
      w1 = rk[95:64] ^ w0;
      w2 = rk[63:32] ^ w1;
      w3 = rk[31:0]  ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   // Undo one forward step: w1..w3 fall out of the XOR chain, w0 needs new w3.
   function automatic logic [127:0] key_step_inv(input logic [127:0] rk, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3;
      w3 = rk[31:0]  ^ rk[63:32];
      w2 = rk[63:32] ^ rk[95:64];
      w1 = rk[95:64] ^ rk[127:96];
      w0 = rk[127:96] ^ sub_rot_word(w3) ^ {rc, 24'h000000};
      return {w0, w1, w2, w3};
   endfunction

   // ---------------------------------------------------------------------
   // Inverse round transforms; byte n lives at bits [127-8n -: 8]
   // ---------------------------------------------------------------------
   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8];
      return o;
   endfunction

   function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int n = 0; n < 16; n++)
         o[127 - 8*n -: 8] = inv_sbox(s[127 - 8*n -: 8]);
      return o;
   endfunction

   // Row i of the {0e,0b,0d,09} circulant, built from doubling chains.
   function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
      logic [7:0] a [4];
      logic [7:0] m9 [4], mb [4], md [4], me [4];
      logic [7:0] x2, x4, x8;
      logic [31:0] o;
      o = '0;
      for (int i = 0; i < 4; i++) begin
         a[i]  = col[31 - 8*i -: 8];
         x2    = xtime(a[i]);
         x4    = xtime(x2);
         x8    = xtime(x4);
         m9[i] = x8 ^ a[i];
         mb[i] = x8 ^ x2 ^ a[i];
         md[i] = x8 ^ x4 ^ a[i];
         me[i] = x8 ^ x4 ^ x2;
      end
      for (int i = 0; i < 4; i++)
         o[31 - 8*i -: 8] = me[i] ^ mb[(i + 1) % 4] ^ md[(i + 2) % 4] ^ m9[(i + 3) % 4];
      return o;
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      return {inv_mix_col(s[127:96]), inv_mix_col(s[95:64]),
              inv_mix_col(s[63:32]),  inv_mix_col(s[31:0])};
   endfunction

   // ---------------------------------------------------------------------
   // Datapath
   // ---------------------------------------------------------------------
   // During ROUND, cnt_q is the round index i and rk_q holds rk_(i+1).
   assign rk_fwd_d = key_step_fwd(rk_q, rcon(cnt_q));
   assign rk_inv_d = key_step_inv(rk_q, rcon(cnt_q + 4'd1));
   assign last_d   = inv_sub_bytes(inv_shift_rows(st_q)) ^ rk_inv_d;
   assign round_d  = inv_mix_columns(last_d);

   // Sequencer: IDLE -> EXPAND (10 key steps) -> ROUND (10 inverse rounds).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // NOTE: rk_q and st_q are pure datapath, only read after a start
         // loads them, so they carry no reset and cost no reset routing.
         fsm_q    <= IDLE;
         cnt_q    <= 4'd0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (fsm_q)
            IDLE: begin
               if (start) begin
                  rk_q   <= key;
                  st_q   <= block;
                  cnt_q  <= 4'd1;
                  busy_q <= 1'b1;
                  fsm_q  <= EXPAND;
               end
            end
            EXPAND: begin
               rk_q <= rk_fwd_d;
               if (cnt_q == 4'd10) begin
                  st_q  <= st_q ^ rk_fwd_d;
                  cnt_q <= 4'd9;
                  fsm_q <= ROUND;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            ROUND: begin
               rk_q <= rk_inv_d;
               if (cnt_q == 4'd0) begin
                  result_q <= last_d;
                  done_q   <= 1'b1;
                  busy_q   <= 1'b0;
                  fsm_q    <= IDLE;
               end else begin
                  st_q  <= round_d;
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            default: fsm_q <= IDLE;
         endcase
      end
   end

   assign result = result_q;
   assign busy   = busy_q;
   assign done   = done_q;

endmodule

// File: tb/tb_aes_decrypt.sv
// tb_aes_decrypt: drives known-answer and random vectors into aes_decrypt and
// compares against a table-driven AES-128 reference with a full key schedule.
module tb_aes_decrypt;

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] AB_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] AB_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] AB_PT  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] F1_KEY = 128'hf1fc7f1fc7f1fc7f1fc7f1fc7f1fc7f1;
   localparam logic [127:0] F1_CT  = 128'hd2062eeec0e7f718a5c91f4db25d0658;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [127:0] block = '0;
   logic [127:0] key = '0;
   logic [127:0] result;
   logic         busy;
   logic         done;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0]  sbox_t [256];
   logic [7:0]  inv_sbox_t [256];
   logic [31:0] wk [44];

   aes_decrypt dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .block  (block),
      .key    (key),
      .result (result),
      .busy   (busy),
      .done   (done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      logic [15:0] d;
      d = {v, v};
      return d[15 - n -: 8];
   endfunction

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa, bb;
      p = 8'h00; aa = a; bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
         bb = bb >> 1;
      end
      return p;
   endfunction

   // Walk the multiplicative group with generator 3 and its inverse in step.
   task automatic build_sbox;
      logic [7:0] p, q, x;
      p = 8'h01; q = 8'h01;
      for (int i = 0; i < 255; i++) begin
         p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ {q[6:0], 1'b0};
         q = q ^ {q[5:0], 2'b00};
         q = q ^ {q[3:0], 4'h0};
         if (q[7]) q = q ^ 8'h09;
         x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
         sbox_t[p] = x ^ 8'h63;
      end
      sbox_t[0] = 8'h63;
      for (int i = 0; i < 256; i++) inv_sbox_t[sbox_t[i]] = 8'(i);
   endtask

   task automatic expand_key(input logic [127:0] k);
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) wk[i] = k[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = wk[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
            t = t ^ {rc, 24'h000000};
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
         end
         wk[i] = wk[i-4] ^ t;
      end
   endtask

   function automatic logic [7:0] rk_byte(input int r, input int n);
      logic [31:0] w;
      w = wk[4*r + n/4];
      return w[31 - 8*(n%4) -: 8];
   endfunction

   task automatic model_decrypt(input logic [127:0] ct, input logic [127:0] k, output logic [127:0] pt);
      logic [7:0] s [16];
      logic [7:0] t [16];
      logic [7:0] a0, a1, a2, a3;
      expand_key(k);
      for (int n = 0; n < 16; n++) s[n] = ct[127 - 8*n -: 8] ^ rk_byte(10, n);
      for (int rnd = 9; rnd >= 0; rnd--) begin
         for (int row = 0; row < 4; row++)
            for (int col = 0; col < 4; col++)
               t[row + 4*col] = s[row + 4*((col + 4 - row) % 4)];
         for (int n = 0; n < 16; n++) s[n] = inv_sbox_t[t[n]] ^ rk_byte(rnd, n);
         if (rnd > 0) begin
            for (int col = 0; col < 4; col++) begin
               a0 = s[4*col]; a1 = s[4*col+1]; a2 = s[4*col+2]; a3 = s[4*col+3];
               s[4*col]   = gm(a0, 8'h0e) ^ gm(a1, 8'h0b) ^ gm(a2, 8'h0d) ^ gm(a3, 8'h09);
               s[4*col+1] = gm(a0, 8'h09) ^ gm(a1, 8'h0e) ^ gm(a2, 8'h0b) ^ gm(a3, 8'h0d);
               s[4*col+2] = gm(a0, 8'h0d) ^ gm(a1, 8'h09) ^ gm(a2, 8'h0e) ^ gm(a3, 8'h0b);
               s[4*col+3] = gm(a0, 8'h0b) ^ gm(a1, 8'h0d) ^ gm(a2, 8'h09) ^ gm(a3, 8'h0e);
            end
         end
      end
      pt = '0;
      for (int n = 0; n < 16; n++) pt[127 - 8*n -: 8] = s[n];
   endtask

   task automatic model_encrypt(input logic [127:0] pt, input logic [127:0] k, output logic [127:0] ct);
      logic [7:0] s [16];
      logic [7:0] t [16];
      logic [7:0] a0, a1, a2, a3;
      expand_key(k);
      for (int n = 0; n < 16; n++) s[n] = pt[127 - 8*n -: 8] ^ rk_byte(0, n);
      for (int rnd = 1; rnd <= 10; rnd++) begin
         for (int n = 0; n < 16; n++) t[n] = sbox_t[s[n]];
         for (int row = 0; row < 4; row++)
            for (int col = 0; col < 4; col++)
               s[row + 4*col] = t[row + 4*((col + row) % 4)];
         if (rnd < 10) begin
            for (int col = 0; col < 4; col++) begin
               a0 = s[4*col]; a1 = s[4*col+1]; a2 = s[4*col+2]; a3 = s[4*col+3];
               s[4*col]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
               s[4*col+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
               s[4*col+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
               s[4*col+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
            end
         end
         for (int n = 0; n < 16; n++) s[n] = s[n] ^ rk_byte(rnd, n);
      end
      ct = '0;
      for (int n = 0; n < 16; n++) ct[127 - 8*n -: 8] = s[n];
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic start_op(input logic [127:0] b, input logic [127:0] k);
      start = 1'b1;
      block = b;
      key   = k;
      tick();
      start = 1'b0;
      block = {$urandom, $urandom, $urandom, $urandom};
      key   = {$urandom, $urandom, $urandom, $urandom};
   endtask

   // Counts edges since the accepting edge until done is seen (bounded).
   task automatic wait_done(input string tag, input int from, output int lat);
      logic busy_bad;
      busy_bad = 1'b0;
      lat = from;
      while (!done && lat < 40) begin
         if (!busy) busy_bad = 1'b1;
         tick();
         lat++;
      end
      check({tag, "_done_seen"}, 128'(done), 128'(1));
      check({tag, "_busy_during"}, 128'(busy_bad), 128'(0));
      check({tag, "_busy_in_done"}, 128'(busy), 128'(0));
   endtask

   task automatic run_vec(input string tag, input logic [127:0] b, input logic [127:0] k,
                          input logic [127:0] exp);
      int lat;
      start_op(b, k);
      wait_done(tag, 0, lat);
      check({tag, "_latency"}, 128'(lat), 128'(20));
      check({tag, "_result"}, result, exp);
      tick();
      check({tag, "_done_width"}, 128'(done), 128'(0));
      check({tag, "_result_hold"}, result, exp);
   endtask

   task automatic count_dones(input int cycles, output int n);
      n = 0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         if (done) n++;
      end
   endtask

   initial begin
      logic [127:0] exp, pt, ct, re, rk;
      int lat, extra;

      build_sbox();

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_result", result, '0);
      check("reset_busy", 128'(busy), 128'(0));
      check("reset_done", 128'(done), 128'(0));
      rst_n = 1'b1;
      tick();

      // Known-answer vectors
      run_vec("c1", C1_CT, C1_KEY, C1_PT);
      run_vec("appb", AB_CT, AB_KEY, AB_PT);
      model_decrypt(F1_CT, F1_KEY, exp);
      run_vec("f1", F1_CT, F1_KEY, exp);
      model_encrypt(result, F1_KEY, re);
      check("f1_reencrypt", re, F1_CT);

      // Start while busy is ignored
      start_op(C1_CT, C1_KEY);
      repeat (4) tick();
      start = 1'b1; block = AB_CT; key = AB_KEY;
      tick();
      start = 1'b0;
      wait_done("ign", 5, lat);
      check("ign_latency", 128'(lat), 128'(20));
      check("ign_result", result, C1_PT);
      count_dones(25, extra);
      check("ign_no_second_done", 128'(extra), 128'(0));

      // Reset mid-operation
      start_op(C1_CT, C1_KEY);
      repeat (11) tick();
      rst_n = 1'b0;
      tick();
      check("midrst_result", result, '0);
      check("midrst_busy", 128'(busy), 128'(0));
      check("midrst_done", 128'(done), 128'(0));
      rst_n = 1'b1;
      count_dones(25, extra);
      check("midrst_no_done", 128'(extra), 128'(0));
      check("midrst_result_held", result, '0);
      run_vec("midrst_fresh", AB_CT, AB_KEY, AB_PT);

      // Start accepted in the done cycle
      start_op(C1_CT, C1_KEY);
      wait_done("b2b1", 0, lat);
      check("b2b1_result", result, C1_PT);
      start_op(AB_CT, AB_KEY);
      check("b2b_busy_after_restart", 128'(busy), 128'(1));
      check("b2b_done_dropped", 128'(done), 128'(0));
      wait_done("b2b2", 0, lat);
      check("b2b2_latency", 128'(lat), 128'(20));
      check("b2b2_result", result, AB_PT);
      tick();

      // Random vectors: encrypt a random plaintext, decrypt it on the DUT
      for (int it = 0; it < 8; it++) begin
         rk = {$urandom, $urandom, $urandom, $urandom};
         pt = {$urandom, $urandom, $urandom, $urandom};
         model_encrypt(pt, rk, ct);
         model_decrypt(ct, rk, exp);
         start_op(ct, rk);
         wait_done("rand", 0, lat);
         check("rand_latency", 128'(lat), 128'(20));
         check("rand_result_model", result, exp);
         check("rand_result_plain", result, pt);
         if (it % 2 == 1) tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
